riscv_ctrl_fsm: RTL and testbench
=================================

RISCV_CTRL_FSM -- requirements
Module: riscv_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inst  input  32  instruction word from instruction memory
- inst_valid  input  1  inst valid this cycle
- inst_req  output  1  fetch request
- br_eq  input  1  branch comparator equal
- br_lt  input  1  branch comparator less-than
- mem_ready  input  1  data memory access complete
- Asel  output  1  ALU A operand select: 0 = rs1 data, 1 = pc
- Bsel  output  1  ALU B operand select: 0 = rs2 data, 1 = imm
- ALUSel  output  4  ALU opcode: 0 none, 1 add, 2 sub, 3 sll, 4 slt, 5 sltu, 6 xor, 7 srl, 8 sra, 9 or, 10 and
- ImmSel  output  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J
- BrUn  output  1  unsigned branch compare
- MemRW  output  1  data memory write strobe
- RegWEn  output  1  register file write enable
- WBSel  output  2  writeback source: 0 mem, 1 alu, 2 pc+4, 3 imm
- PCSel  output  1  next pc source: 0 = pc+4, 1 = alu
- pc_en  output  1  pc update strobe
- trap  output  1  illegal-instruction halt flag
REQ-003 There SHALL be no parameters.

Function
REQ-004 All outputs SHALL be registered; none SHALL depend combinationally on inputs.
REQ-005 The FSM SHALL have these states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-006 FETCH: inst_req=1; when inst_valid=1, inst SHALL be latched into ir and the FSM SHALL go to DECODE; otherwise it SHALL stay in FETCH.
REQ-007 DECODE: decode ir[6:0]; drive ImmSel and BrUn. Legal opcodes go to EXEC; any other goes to the illegal path (REQ-016).
REQ-008 EXEC: Asel, Bsel and ALUSel SHALL be driven and held constant from DECODE exit until WB exit. Branch taken SHALL be captured from br_eq/br_lt per funct3: beq, bne, blt, bge, bltu, bgeu. Loads/stores go to MEM; all others go to WB.
REQ-009 Operand selection per opcode:
- R (0110011): Asel0 Bsel0.
- OP-IMM (0010011): Asel0 Bsel1 ImmSel0.
- LOAD (0000011): Asel0 Bsel1 add ImmSel0.
- STORE (0100011): Asel0 Bsel1 add ImmSel1.
- BRANCH (1100011): Asel1 Bsel1 add ImmSel2, BrUn=funct3[1].
- JAL (1101111): Asel1 Bsel1 add ImmSel4.
- JALR (1100111): Asel0 Bsel1 add ImmSel0.
- LUI (0110111): ImmSel3, WBSel3, ALUSel0.
- AUIPC (0010111): Asel1 Bsel1 add ImmSel3.
REQ-010 ALU function from funct3:
- 000: R-type with funct7[5]=1 selects sub; otherwise add. OP-IMM never selects sub.
- 001: sll. 010: slt. 011: sltu. 100: xor. 110: or. 111: and.
- 101: sra if funct7[5]=1, else srl.
REQ-011 MEM: MemRW=1 for STORE only, held until mem_ready=1. On mem_ready the FSM SHALL go to WB. mem_ready outside MEM SHALL be ignored.
REQ-012 WB SHALL last exactly one cycle with pc_en=1.
- RegWEn=1 for R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC; RegWEn=0 for STORE and BRANCH.
- WBSel: 0 LOAD, 2 JAL/JALR, 3 LUI, 1 otherwise.
- PCSel=1 for JAL, JALR and taken branches; 0 otherwise.
- Next state SHALL be FETCH.
REQ-013 RegWEn, MemRW and pc_en SHALL be 0 in every state not named above for them.
REQ-014 Latency SHALL be: inst_valid accept cycle N, DECODE N+1, EXEC N+2, WB N+3 (non-memory instructions); a memory instruction adds one MEM cycle plus any mem_ready wait cycles.
REQ-015 inst_valid outside FETCH SHALL be ignored.

Reset
REQ-016 While rst=1, state SHALL be FETCH, ir=0 and every output SHALL be 0, asynchronously, including when rst is asserted mid-instruction (no RegWEn/MemRW/pc_en pulse). inst_req SHALL first assert on the first clk edge after rst deasserts.

Configuration
REQ-017 Macro CTRL_ILLEGAL_TRAP_EN:
- Defined: an illegal opcode goes DECODE->TRAP; trap=1 and all strobes 0 until reset.
- Undefined: an illegal opcode is a NOP: DECODE->WB with RegWEn=0, PCSel=0, pc_en=1; trap is tied 0.

Verification
REQ-018 ADD 0x002081B3 -> ALUSel=1, Asel=0, Bsel=0; RegWEn=1, WBSel=1 exactly at N+3 for one cycle.
REQ-019 SRAI 0x4032D293 -> ALUSel=8, Bsel=1, ImmSel=0; SUB 0x40208133 -> ALUSel=2.
REQ-020 BEQ 0x00208463: with br_eq=1 -> WB PCSel=1, RegWEn=0; with br_eq=0 -> PCSel=0, pc_en=1.
REQ-021 SW 0x0020A223 with mem_ready low 3 cycles -> MemRW=1 for 4 MEM cycles, RegWEn=0, then WB.
REQ-022 Instruction 0xFFFFFFFF -> with macro: trap=1 held, inst_req=0 for 20 cycles; without macro: pc_en pulse, RegWEn=0, back to FETCH.
REQ-023 rst pulsed during a SW in MEM -> MemRW drops to 0 immediately; FETCH restarts after release.

Source files
------------

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with fully registered control outputs.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt in TRAP instead of retiring as a NOP.
module riscv_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_req,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        mem_ready,
  output logic        Asel,
  output logic        Bsel,
  output logic [3:0]  ALUSel,
  output logic [2:0]  ImmSel,
  output logic        BrUn,
  output logic        MemRW,
  output logic        RegWEn,
  output logic [1:0]  WBSel,
  output logic        PCSel,
  output logic        pc_en,
  output logic        trap
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        taken_q, taken_d;

  logic        inst_req_q, inst_req_d;
  logic        asel_q, asel_d;
  logic        bsel_q, bsel_d;
  logic [3:0]  alusel_q, alusel_d;
  logic [2:0]  immsel_q, immsel_d;
  logic        brun_q, brun_d;
  logic        memrw_q, memrw_d;
  logic        regwen_q, regwen_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic        pcsel_q, pcsel_d;
  logic        pc_en_q, pc_en_d;

  // Decoded fields of the instruction that will be held in ir next cycle
  logic        dec_legal, dec_asel, dec_bsel, dec_brun, dec_rwe;
  logic        dec_jump, dec_mem, dec_store, dec_branch;
  logic [3:0]  dec_alu;
  logic [2:0]  dec_imm;
  logic [1:0]  dec_wbsel;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        br_cond;

  function automatic logic [3:0] alu_f(input logic [2:0] fn3, input logic alt, input logic rtype);
    logic [3:0] r;
    case (fn3)
      3'b000:  r = (rtype && alt) ? 4'd2 : 4'd1;
      3'b001:  r = 4'd3;
      3'b010:  r = 4'd4;
      3'b011:  r = 4'd5;
      3'b100:  r = 4'd6;
      3'b101:  r = alt ? 4'd8 : 4'd7;
      3'b110:  r = 4'd9;
      default: r = 4'd10;
    endcase
    return r;
  endfunction

  always_comb begin
    opc        = ir_d[6:0];
    f3         = ir_d[14:12];
    dec_legal  = 1'b0;
    dec_asel   = 1'b0;
    dec_bsel   = 1'b0;
    dec_alu    = 4'd0;
    dec_imm    = 3'd0;
    dec_brun   = 1'b0;
    dec_rwe    = 1'b0;
    dec_wbsel  = 2'd1;
    dec_jump   = 1'b0;
    dec_mem    = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    case (opc)
      OP_R: begin
        dec_legal = 1'b1;
        dec_alu   = alu_f(f3, ir_d[30], 1'b1);
        dec_rwe   = 1'b1;
      end
      OP_IMM: begin
        dec_legal = 1'b1;
        dec_bsel  = 1'b1;
        dec_alu   = alu_f(f3, ir_d[30], 1'b0);
        dec_rwe   = 1'b1;
      end
      OP_LOAD: begin
        dec_legal = 1'b1;
        dec_bsel  = 1'b1;
        dec_alu   = 4'd1;
        dec_rwe   = 1'b1;
        dec_wbsel = 2'd0;
        dec_mem   = 1'b1;
      end
      OP_STORE: begin
        dec_legal = 1'b1;
        dec_bsel  = 1'b1;
        dec_alu   = 4'd1;
        dec_imm   = 3'd1;
        dec_mem   = 1'b1;
        dec_store = 1'b1;
      end
      OP_BRANCH: begin
        dec_legal  = 1'b1;
        dec_asel   = 1'b1;
        dec_bsel   = 1'b1;
        dec_alu    = 4'd1;
        dec_imm    = 3'd2;
        dec_brun   = f3[1];
        dec_branch = 1'b1;
      end
      OP_JAL: begin
        dec_legal = 1'b1;
        dec_asel  = 1'b1;
        dec_bsel  = 1'b1;
        dec_alu   = 4'd1;
        dec_imm   = 3'd4;
        dec_rwe   = 1'b1;
        dec_wbsel = 2'd2;
        dec_jump  = 1'b1;
      end
      OP_JALR: begin
        dec_legal = 1'b1;
        dec_bsel  = 1'b1;
        dec_alu   = 4'd1;
        dec_rwe   = 1'b1;
        dec_wbsel = 2'd2;
        dec_jump  = 1'b1;
      end
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_imm   = 3'd3;
        dec_rwe   = 1'b1;
        dec_wbsel = 2'd3;
      end
      OP_AUIPC: begin
        dec_legal = 1'b1;
        dec_asel  = 1'b1;
        dec_bsel  = 1'b1;
        dec_alu   = 4'd1;
        dec_imm   = 3'd3;
        dec_rwe   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = ~br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = ~br_lt;
      3'b110:  br_cond = br_lt;
      3'b111:  br_cond = ~br_lt;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    taken_d = taken_q;
    case (state_q)
      FETCH: begin
        if (inst_valid) begin
          ir_d    = inst;
          taken_d = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) state_d = EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else           state_d = TRAP;
`else
        else           state_d = WB;
`endif
      end
      EXEC: begin
        taken_d = dec_branch & br_cond;
        state_d = dec_mem ? MEM : WB;
      end
      MEM:     if (mem_ready) state_d = WB;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are computed for the state being entered so the registered values line up with state_q
  always_comb begin
    inst_req_d = (state_d == FETCH);
    asel_d     = 1'b0;
    bsel_d     = 1'b0;
    alusel_d   = 4'd0;
    immsel_d   = 3'd0;
    brun_d     = 1'b0;
    memrw_d    = 1'b0;
    regwen_d   = 1'b0;
    wbsel_d    = 2'd0;
    pcsel_d    = 1'b0;
    pc_en_d    = 1'b0;
    if (state_d == DECODE || state_d == EXEC || state_d == MEM || state_d == WB) begin
      asel_d   = dec_asel;
      bsel_d   = dec_bsel;
      alusel_d = dec_alu;
      immsel_d = dec_imm;
      brun_d   = dec_brun;
    end
    if (state_d == MEM) memrw_d = dec_store;
    if (state_d == WB) begin
      pc_en_d  = 1'b1;
      regwen_d = dec_rwe;
      wbsel_d  = dec_wbsel;
      pcsel_d  = dec_jump | taken_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      ir_q       <= 32'd0;
      taken_q    <= 1'b0;
      inst_req_q <= 1'b0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      alusel_q   <= 4'd0;
      immsel_q   <= 3'd0;
      brun_q     <= 1'b0;
      memrw_q    <= 1'b0;
      regwen_q   <= 1'b0;
      wbsel_q    <= 2'd0;
      pcsel_q    <= 1'b0;
      pc_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      taken_q    <= taken_d;
      inst_req_q <= inst_req_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      alusel_q   <= alusel_d;
      immsel_q   <= immsel_d;
      brun_q     <= brun_d;
      memrw_q    <= memrw_d;
      regwen_q   <= regwen_d;
      wbsel_q    <= wbsel_d;
      pcsel_q    <= pcsel_d;
      pc_en_q    <= pc_en_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= (state_d == TRAP);
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign inst_req = inst_req_q;
  assign Asel     = asel_q;
  assign Bsel     = bsel_q;
  assign ALUSel   = alusel_q;
  assign ImmSel   = immsel_q;
  assign BrUn     = brun_q;
  assign MemRW    = memrw_q;
  assign RegWEn   = regwen_q;
  assign WBSel    = wbsel_q;
  assign PCSel    = pcsel_q;
  assign pc_en    = pc_en_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed-vector bench for riscv_ctrl_fsm: instruction table plus reset and illegal-opcode sequences.
module tb_riscv_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'd0;
  logic        inst_valid = 1'b0;
  logic        br_eq = 1'b0;
  logic        br_lt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        inst_req, Asel, Bsel, BrUn, MemRW, RegWEn, PCSel, pc_en, trap;
  logic [3:0]  ALUSel;
  logic [2:0]  ImmSel;
  logic [1:0]  WBSel;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_ctrl_fsm dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .inst_req(inst_req),
    .br_eq(br_eq), .br_lt(br_lt), .mem_ready(mem_ready),
    .Asel(Asel), .Bsel(Bsel), .ALUSel(ALUSel), .ImmSel(ImmSel), .BrUn(BrUn),
    .MemRW(MemRW), .RegWEn(RegWEn), .WBSel(WBSel), .PCSel(PCSel), .pc_en(pc_en), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        beq, blt;
    logic        mem, store;
    int          wait_n;
    logic        asel, bsel;
    logic [3:0]  alu;
    logic [2:0]  imm;
    logic        brun;
    logic        rwe;
    logic [1:0]  wbsel;
    logic        pcsel;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] ins, input logic beq, input logic blt,
                     input logic mem, input logic store, input int wait_n,
                     input logic asel, input logic bsel, input logic [3:0] alu, input logic [2:0] imm,
                     input logic brun, input logic rwe, input logic [1:0] wbsel, input logic pcsel);
    vec_t v;
    v.name = nm; v.ins = ins; v.beq = beq; v.blt = blt; v.mem = mem; v.store = store;
    v.wait_n = wait_n; v.asel = asel; v.bsel = bsel; v.alu = alu; v.imm = imm; v.brun = brun;
    v.rwe = rwe; v.wbsel = wbsel; v.pcsel = pcsel;
    tbl.push_back(v);
  endtask

  // Called at a negedge while the FSM sits in FETCH
  task automatic run_vec(input vec_t v);
    chk({v.name, " inst_req"}, 32'(inst_req), 32'(1'b1));
    inst = v.ins; inst_valid = 1'b1; br_eq = v.beq; br_lt = v.blt; mem_ready = 1'b0;
    @(negedge clk); // DECODE
    chk({v.name, " ImmSel"}, 32'(ImmSel), 32'(v.imm));
    chk({v.name, " BrUn"}, 32'(BrUn), 32'(v.brun));
    chk({v.name, " dec pc_en"}, 32'(pc_en), 32'(1'b0));
    chk({v.name, " dec inst_req"}, 32'(inst_req), 32'(1'b0));
    inst = 32'hFFFF_FFFF; // stays valid but must be ignored outside FETCH
    @(negedge clk); // EXEC
    inst_valid = 1'b0;
    chk({v.name, " Asel"}, 32'(Asel), 32'(v.asel));
    chk({v.name, " Bsel"}, 32'(Bsel), 32'(v.bsel));
    chk({v.name, " ALUSel"}, 32'(ALUSel), 32'(v.alu));
    chk({v.name, " exec strobes"}, 32'({MemRW, RegWEn, pc_en}), 32'(3'b000));
    if (v.mem) begin
      for (int k = 0; k <= v.wait_n; k++) begin
        @(negedge clk); // MEM
        chk({v.name, " MemRW"}, 32'(MemRW), 32'(v.store));
        chk({v.name, " mem pc_en"}, 32'(pc_en), 32'(1'b0));
        chk({v.name, " mem ALUSel"}, 32'(ALUSel), 32'(v.alu));
        mem_ready = (k == v.wait_n);
      end
    end
    @(negedge clk); // WB
    mem_ready = 1'b0;
    chk({v.name, " pc_en"}, 32'(pc_en), 32'(1'b1));
    chk({v.name, " RegWEn"}, 32'(RegWEn), 32'(v.rwe));
    chk({v.name, " WBSel"}, 32'(WBSel), 32'(v.wbsel));
    chk({v.name, " PCSel"}, 32'(PCSel), 32'(v.pcsel));
    chk({v.name, " wb MemRW"}, 32'(MemRW), 32'(1'b0));
    chk({v.name, " wb ALUSel"}, 32'(ALUSel), 32'(v.alu));
    @(negedge clk); // FETCH
    chk({v.name, " post pc_en"}, 32'(pc_en), 32'(1'b0));
    chk({v.name, " post RegWEn"}, 32'(RegWEn), 32'(1'b0));
    chk({v.name, " post inst_req"}, 32'(inst_req), 32'(1'b1));
  endtask

  initial begin
    //   name     inst          beq  blt  mem st wait asel bsel alu  imm  brun rwe wb  pcs
    add("ADD",   32'h002081B3, 0, 0, 0, 0, 0, 0, 0, 4'd1,  3'd0, 0, 1, 2'd1, 0);
    add("SUB",   32'h40208133, 0, 0, 0, 0, 0, 0, 0, 4'd2,  3'd0, 0, 1, 2'd1, 0);
    add("SRL",   32'h0020D0B3, 0, 0, 0, 0, 0, 0, 0, 4'd7,  3'd0, 0, 1, 2'd1, 0);
    add("AND",   32'h0020F0B3, 0, 0, 0, 0, 0, 0, 0, 4'd10, 3'd0, 0, 1, 2'd1, 0);
    add("SRAI",  32'h4032D293, 0, 0, 0, 0, 0, 0, 1, 4'd8,  3'd0, 0, 1, 2'd1, 0);
    add("ADDIhi",32'h40000093, 0, 0, 0, 0, 0, 0, 1, 4'd1,  3'd0, 0, 1, 2'd1, 0);
    add("XORI",  32'h0040C093, 0, 0, 0, 0, 0, 0, 1, 4'd6,  3'd0, 0, 1, 2'd1, 0);
    add("BEQt",  32'h00208463, 1, 0, 0, 0, 0, 1, 1, 4'd1,  3'd2, 0, 0, 2'd1, 1);
    add("BEQn",  32'h00208463, 0, 1, 0, 0, 0, 1, 1, 4'd1,  3'd2, 0, 0, 2'd1, 0);
    add("BNEn",  32'h00209463, 1, 0, 0, 0, 0, 1, 1, 4'd1,  3'd2, 0, 0, 2'd1, 0);
    add("BLTUt", 32'h0020E463, 0, 1, 0, 0, 0, 1, 1, 4'd1,  3'd2, 1, 0, 2'd1, 1);
    add("BGEt",  32'h0020D463, 0, 0, 0, 0, 0, 1, 1, 4'd1,  3'd2, 0, 0, 2'd1, 1);
    add("SW",    32'h0020A223, 0, 0, 1, 1, 3, 0, 1, 4'd1,  3'd1, 0, 0, 2'd1, 0);
    add("LW",    32'h0000A083, 0, 0, 1, 0, 1, 0, 1, 4'd1,  3'd0, 0, 1, 2'd0, 0);
    add("JAL",   32'h008000EF, 0, 0, 0, 0, 0, 1, 1, 4'd1,  3'd4, 0, 1, 2'd2, 1);
    add("JALR",  32'h000080E7, 0, 0, 0, 0, 0, 0, 1, 4'd1,  3'd0, 0, 1, 2'd2, 1);
    add("LUI",   32'h123450B7, 0, 0, 0, 0, 0, 0, 0, 4'd0,  3'd3, 0, 1, 2'd3, 0);
    add("AUIPC", 32'h00001097, 0, 0, 0, 0, 0, 1, 1, 4'd1,  3'd3, 0, 1, 2'd1, 0);

    // Reset state, then release and check inst_req only rises on the next edge
    @(negedge clk);
    chk("rst inst_req", 32'(inst_req), 32'(1'b0));
    chk("rst strobes", 32'({MemRW, RegWEn, pc_en, trap}), 32'(4'b0000));
    chk("rst ALUSel", 32'(ALUSel), 32'(4'd0));
    chk("rst WBSel", 32'(WBSel), 32'(2'd0));
    rst = 1'b0;
    #1;
    chk("rel inst_req pre-edge", 32'(inst_req), 32'(1'b0));
    @(negedge clk);
    chk("rel inst_req", 32'(inst_req), 32'(1'b1));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Illegal opcode
    inst = 32'hFFFF_FFFF; inst_valid = 1'b1;
    @(negedge clk); // DECODE
    inst_valid = 1'b0;
    chk("ill dec pc_en", 32'(pc_en), 32'(1'b0));
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("ill trap", 32'(trap), 32'(1'b1));
      chk("ill inst_req", 32'(inst_req), 32'(1'b0));
      chk("ill strobes", 32'({MemRW, RegWEn, pc_en}), 32'(3'b000));
    end
    rst = 1'b1;
    #1;
    chk("ill rst trap", 32'(trap), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`else
    @(negedge clk); // WB as a NOP
    chk("ill pc_en", 32'(pc_en), 32'(1'b1));
    chk("ill RegWEn", 32'(RegWEn), 32'(1'b0));
    chk("ill PCSel", 32'(PCSel), 32'(1'b0));
    chk("ill trap", 32'(trap), 32'(1'b0));
    @(negedge clk);
`endif
    chk("ill back inst_req", 32'(inst_req), 32'(1'b1));
    chk("ill back pc_en", 32'(pc_en), 32'(1'b0));

    // Reset asserted while a store waits in MEM
    inst = 32'h0020A223; inst_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk); // DECODE
    inst_valid = 1'b0;
    @(negedge clk); // EXEC
    @(negedge clk); // MEM
    chk("mrst MemRW before", 32'(MemRW), 32'(1'b1));
    @(negedge clk); // still MEM
    chk("mrst MemRW held", 32'(MemRW), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("mrst MemRW async", 32'(MemRW), 32'(1'b0));
    chk("mrst strobes async", 32'({RegWEn, pc_en, inst_req}), 32'(3'b000));
    mem_ready = 1'b1; // must not matter while in reset or after it
    @(posedge clk);
    #1;
    chk("mrst during edge", 32'({MemRW, RegWEn, pc_en, inst_req}), 32'(4'b0000));
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mrst restart inst_req", 32'(inst_req), 32'(1'b1));
    chk("mrst restart MemRW", 32'(MemRW), 32'(1'b0));
    run_vec(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
